riscv_hazard_ctrl: RTL

RISCV_HAZARD_CTRL -- requirements
Module: riscv_hazard_ctrl

---
 rtl/riscv_hazard_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: RAW interlock from a 3-entry rd scoreboard (EX/MEM/WB),
// data-memory freeze, and branch-redirect flush, with a saturating stall counter.
module riscv_hazard_ctrl #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [4:0]           id_rd,
  input  logic                 id_regwen,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 pipe_en,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam int unsigned SB_DEPTH = 3;
  localparam int unsigned REG_W    = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_MEMW  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  logic [REG_W-1:0]     r_rd [SB_DEPTH];
  logic [SB_DEPTH-1:0]  r_v;
  state_e               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic   w_haz;
  state_e w_cond;

  // RAW check against every live producer; no forwarding, so WB matches stall too
  always_comb begin
    w_haz = 1'b0;
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      if (r_v[i] && ((id_use_rs1 && (r_rd[i] == id_rs1)) ||
                     (id_use_rs2 && (r_rd[i] == id_rs2)))) begin
        w_haz = 1'b1;
      end
    end
    w_haz = w_haz & id_valid;
  end

  // Condition select (MEMW > FLUSH > HAZ > RUN) and zero-latency pipeline controls
  always_comb begin
    w_cond      = ST_RUN;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_en     = 1'b1;
    if (mem_req && !mem_ack)  w_cond = ST_MEMW;
    else if (ex_redirect)     w_cond = ST_FLUSH;
    else if (w_haz)           w_cond = ST_HAZ;

    if (!reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_en     = 1'b0;
    end else begin
      case (w_cond)
        ST_MEMW: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          pipe_en = 1'b0;
        end
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        ST_HAZ: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scoreboard shift, registered condition and saturating stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(SB_DEPTH); i++) r_rd[i] <= '0;
      r_v     <= '0;
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_cond;
      if (pipe_en) begin
        r_rd[2] <= r_rd[1];
        r_v[2]  <= r_v[1];
        r_rd[1] <= r_rd[0];
        r_v[1]  <= r_v[0];
        r_rd[0] <= id_rd;
        r_v[0]  <= (w_cond == ST_RUN) & id_valid & id_regwen & (id_rd != 5'd0);
      end
      if (!pc_en && (r_cnt != '1)) r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_cnt;

endmodule
